// File: rtl/seqdet_frame_ctrl.sv
// Frame controller for a bit-serial 1101 detector: serializes words MSB-first and reports per-frame match counts.
// Optional feature: define SEQDET_CNT_SAT_EN to make the match counter saturate instead of wrap.
module seqdet_frame_ctrl #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              det_rst,
   output logic              det_in,
   input  logic              det_y,
   output logic              m_valid,
   output logic [CNT_W-1:0]  m_count,
   input  logic              m_ready,
   output logic              busy
);

   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_REPORT = 2'd3;

   logic [1:0]        state_q,   state_d;
   logic [DATA_W-1:0] shift_q,   shift_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              last_q,    last_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;

   logic              in_shift;
   logic              last_bit;
   logic              s_fire;
   logic              m_fire;
   logic [CNT_W-1:0]  cnt_plus;

   // Every output is a decode of registered state, so det_in never depends on det_y.
   always_comb begin
      in_shift = (state_q == ST_SHIFT);
      last_bit = in_shift && (bit_cnt_q == LAST_BIT);
      s_ready  = (state_q == ST_IDLE) || (state_q == ST_WAIT) || (last_bit && !last_q);
      det_rst  = !in_shift;
      det_in   = in_shift && shift_q[DATA_W-1];
      m_valid  = (state_q == ST_REPORT);
      m_count  = m_valid ? cnt_q : '0;
      busy     = (state_q != ST_IDLE);
      s_fire   = s_valid && s_ready;
      m_fire   = m_valid && m_ready;
   end

   always_comb begin
`ifdef SEQDET_CNT_SAT_EN
      cnt_plus = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
`else
      cnt_plus = cnt_q + CNT_W'(1);
`endif
   end

   always_comb begin
      // NOTE: every _d gets a default first so no path through the case infers a latch.
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      last_d    = last_q;
      cnt_d     = cnt_q;

      case (state_q)
         ST_IDLE, ST_WAIT: begin
            if (s_fire) begin
               shift_d   = s_data;
               last_d    = s_last;
               bit_cnt_d = '0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (det_y) begin
               cnt_d = cnt_plus;
            end
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (last_bit) begin
               // Reloading here keeps the detector running, so matches may span words.
               if (s_fire) begin
                  shift_d   = s_data;
                  last_d    = s_last;
                  bit_cnt_d = '0;
               end else if (last_q) begin
                  state_d = ST_REPORT;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_REPORT: begin
            if (m_fire) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         last_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule
